digit_serial_comparator: RTL and testbench

- Parametrised, multi-cycle successor to the team's 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and terminates early on the first differing digit.
- Reports the result on registered one-hot equal / less_than / greater_than flags with a start/busy/done handshake.
- Sits in datapaths where a full-width single-cycle compare would break timing at large WIDTH.

---
 rtl/digit_serial_comparator.sv | 148 ++++++++++++++
 tb/tb_digit_serial_comparator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_comparator.sv
// digit_serial_comparator
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are walked
// MSB-first, DIGIT bits per clock, and the walk stops on the first digit
// that differs. Results land on registered one-hot equal / less_than /
// greater_than flags together with a one-cycle done pulse.
//
// Optional build macro: DIGIT_SERIAL_COMPARATOR_SIGNED_EN
//   When defined, a and b are treated as two's complement. The sign bit of
//   both operands is inverted at capture, which turns signed order into
//   plain unsigned order so the digit walk itself is unchanged.
module digit_serial_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             less_than,
  output logic             greater_than
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NDIG - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [KW-1:0]    k;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             load;
  logic             step;
  logic             finish;
  logic             set_eq;
  logic             set_lt;
  logic             set_gt;

`ifdef DIGIT_SERIAL_COMPARATOR_SIGNED_EN
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
  assign a_in = a ^ SIGN_MASK;
  assign b_in = b ^ SIGN_MASK;
`else
  assign a_in = a;
  assign b_in = b;
`endif

  // The digit under test is always the top DIGIT bits of the shift registers
  assign a_dig = a_sh[WIDTH-1 -: DIGIT];
  assign b_dig = b_sh[WIDTH-1 -: DIGIT];
  assign busy  = (state == RUN);

  // State register; reset throws away any compare in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept start in IDLE, decide or advance one digit in RUN
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    set_eq     = 1'b0;
    set_lt     = 1'b0;
    set_gt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (a_dig > b_dig) begin
          set_gt     = 1'b1;
          finish     = 1'b1;
          next_state = IDLE;
        end else if (a_dig < b_dig) begin
          set_lt     = 1'b1;
          finish     = 1'b1;
          next_state = IDLE;
        end else if (k == LAST_K) begin
          set_eq     = 1'b1;
          finish     = 1'b1;
          next_state = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand shift registers and digit index: load on start, shift per equal digit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      k    <= '0;
    end else if (load) begin
      a_sh <= a_in;
      b_sh <= b_in;
      k    <= '0;
    end else if (step) begin
      a_sh <= a_sh << DIGIT;
      b_sh <= b_sh << DIGIT;
      k    <= k + KW'(1);
    end
  end

  // Result flags hold the last outcome; done pulses for the cycle they change
  always_ff @(posedge clk) begin
    if (rst) begin
      done         <= 1'b0;
      equal        <= 1'b0;
      less_than    <= 1'b0;
      greater_than <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        equal        <= set_eq;
        less_than    <= set_lt;
        greater_than <= set_gt;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_comparator.sv
// tb_digit_serial_comparator
// Directed bench for digit_serial_comparator at WIDTH=16, DIGIT=4.
// Expected results follow DIGIT_SERIAL_COMPARATOR_SIGNED_EN when defined.
module tb_digit_serial_comparator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        equal;
  logic        less_than;
  logic        greater_than;

  int   n_checks;
  int   n_fail;
  logic prev_eq;
  logic prev_lt;
  logic prev_gt;

  digit_serial_comparator #(
    .WIDTH(16),
    .DIGIT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .equal       (equal),
    .less_than   (less_than),
    .greater_than(greater_than)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] av, input logic [15:0] bv);
    start = s;
    a     = av;
    b     = bv;
  endtask

  // Issues start at the current falling edge and returns at the falling edge of the done cycle
  task automatic runCompare(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input int exp_lat, input logic exp_eq, input logic exp_lt,
                            input logic exp_gt);
    int cyc;
    applyStimulus(1'b1, av, bv);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc <= 20) begin
      checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
      checkOutput({tag, " hold"}, {29'd0, equal, less_than, greater_than},
                  {29'd0, prev_eq, prev_lt, prev_gt});
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, " latency"}, 32'(cyc - 1), 32'(exp_lat));
    checkOutput({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " flags"}, {29'd0, equal, less_than, greater_than},
                {29'd0, exp_eq, exp_lt, exp_gt});
    prev_eq = exp_eq;
    prev_lt = exp_lt;
    prev_gt = exp_gt;
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    prev_eq  = 1'b0;
    prev_lt  = 1'b0;
    prev_gt  = 1'b0;
    rst      = 1'b1;
    applyStimulus(1'b0, 16'h0000, 16'h0000);

    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset flags", {29'd0, equal, less_than, greater_than}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] equal operands");
    runCompare("eq_1234", 16'h1234, 16'h1234, 4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("eq_1234 done_pulse", {31'd0, done}, 32'd0);

    $display("[TB] early exit");
`ifdef DIGIT_SERIAL_COMPARATOR_SIGNED_EN
    runCompare("early_9000", 16'h9000, 16'h1000, 1, 1'b0, 1'b1, 1'b0);
`else
    runCompare("early_9000", 16'h9000, 16'h1000, 1, 1'b0, 1'b0, 1'b1);
`endif
    @(negedge clk);
    runCompare("early_0fff", 16'h0FFF, 16'h1000, 1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    runCompare("mid_1200", 16'h1200, 16'h1300, 2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    runCompare("last_1233", 16'h1233, 16'h1234, 4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    $display("[TB] late decision and back-to-back");
    runCompare("late_1235", 16'h1235, 16'h1234, 4, 1'b0, 1'b0, 1'b1);
    runCompare("b2b_0001", 16'h0001, 16'h0002, 4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    $display("[TB] signed/unsigned ordering");
`ifdef DIGIT_SERIAL_COMPARATOR_SIGNED_EN
    runCompare("sign_8000", 16'h8000, 16'h0001, 1, 1'b0, 1'b1, 1'b0);
`else
    runCompare("sign_8000", 16'h8000, 16'h0001, 1, 1'b0, 1'b0, 1'b1);
`endif
    @(negedge clk);

    $display("[TB] ignored start and operand stability");
    applyStimulus(1'b1, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("ign busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b1, 16'hFFFF, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    cyc   = 2;
    while (done !== 1'b1 && cyc <= 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ign done", {31'd0, done}, 32'd1);
    checkOutput("ign latency", 32'(cyc - 1), 32'd4);
    checkOutput("ign flags", {29'd0, equal, less_than, greater_than}, 32'b100);
    prev_eq = 1'b1;
    prev_lt = 1'b0;
    prev_gt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("ign single_done", {31'd0, done}, 32'd0);
    end

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 16'h1234, 16'h1234);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst done", {31'd0, done}, 32'd0);
    checkOutput("rst flags", {29'd0, equal, less_than, greater_than}, 32'd0);
    prev_eq = 1'b0;
    prev_lt = 1'b0;
    prev_gt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rst no_done", {31'd0, done}, 32'd0);
    end
    runCompare("after_rst", 16'hABCD, 16'hABCD, 4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
